// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over one shared memory port, with timeout, illegal-instruction and halt handling.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT    = 16,
  parameter bit          HALT_ON_SYSTEM = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] pc_mux,
  output logic [2:0] mem_to_reg,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic [2:0] mem_offset,
  output logic       unsigned_flag,
  output logic       halted,
  output logic       illegal,
  output logic       mem_err
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam int unsigned    CntW     = $clog2(MEM_TIMEOUT);
  localparam logic [CntW-1:0] WaitLast = CntW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StHalt      = 3'd6,
    StTrap      = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [6:0]      op_q, op_d;
  logic [2:0]      f3_q, f3_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;
  logic            mem_err_q, mem_err_d;

  logic is_load, is_store;
  assign is_load  = (op_q == OpLoad);
  assign is_store = (op_q == OpStore);

  // State, latched instruction fields, wait counter and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      f3_q      <= '0;
      wait_q    <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      f3_q      <= f3_d;
      wait_q    <= wait_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state logic and per-state strobes
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    f3_d          = f3_q;
    halted_d      = halted_q;
    illegal_d     = illegal_q;
    mem_err_d     = mem_err_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    pc_mux        = 2'b00;
    mem_offset    = 3'b000;
    unsigned_flag = 1'b0;

    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_req    = 1'b1;
        mem_offset = 3'b100;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = StDecode;
        end else if (wait_q == WaitLast) begin
          state_d   = StTrap;
          mem_err_d = 1'b1;
        end
      end
      StDecode: begin
        op_d = opcode;
        f3_d = funct3;
        case (opcode)
          OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpImm, OpReg: state_d = StExecute;
          OpLoad: begin
            if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
              state_d   = StTrap;
              illegal_d = 1'b1;
            end else begin
              state_d = StExecute;
            end
          end
          OpStore: begin
            if (funct3[2] || funct3 == 3'b011) begin
              state_d   = StTrap;
              illegal_d = 1'b1;
            end else begin
              state_d = StExecute;
            end
          end
          OpFence: begin
            pc_write = 1'b1;
            state_d  = StFetch;
          end
          OpSystem: begin
            if (HALT_ON_SYSTEM) begin
              state_d  = StHalt;
              halted_d = 1'b1;
            end else begin
              state_d   = StTrap;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = StTrap;
            illegal_d = 1'b1;
          end
        endcase
      end
      StExecute: begin
        if (is_load || is_store) begin
          state_d = StMemory;
        end else if (op_q == OpBranch) begin
          pc_mux   = 2'b11;
          pc_write = branch_taken;
          state_d  = StFetch;
        end else begin
          state_d = StWriteback;
        end
      end
      StMemory: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        // Legal store funct3 values share the load size encoding.
        case (f3_q[1:0])
          2'b00:   mem_offset = 3'b001;
          2'b01:   mem_offset = 3'b010;
          2'b10:   mem_offset = 3'b100;
          default: mem_offset = 3'b000;
        endcase
        unsigned_flag = is_load & f3_q[2];
        if (mem_ready) begin
          if (is_store) begin
            pc_write = 1'b1;
            state_d  = StFetch;
          end else begin
            state_d = StWriteback;
          end
        end else if (wait_q == WaitLast) begin
          state_d   = StTrap;
          mem_err_d = 1'b1;
        end
      end
      StWriteback: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (op_q == OpJal)       pc_mux = 2'b01;
        else if (op_q == OpJalr) pc_mux = 2'b10;
        state_d = StFetch;
      end
      default: ;  // HALT and TRAP absorb until reset
    endcase

    // Counter runs only while a request is held over from the previous cycle.
    if ((state_d == StFetch || state_d == StMemory) && state_d == state_q) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = '0;
    end
  end

  // Static decode driven from the latched instruction fields
  always_comb begin
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    mem_to_reg = 3'b000;
    case (op_q)
      OpImm:    begin alu_src = 1'b1; alu_op = 2'b11; end
      OpReg:    alu_op = 2'b10;
      OpBranch: alu_op = 2'b01;
      OpLoad:   begin alu_src = 1'b1; mem_to_reg = 3'b001; end
      OpStore:  alu_src = 1'b1;
      OpJalr:   begin alu_src = 1'b1; mem_to_reg = 3'b010; end
      OpJal:    mem_to_reg = 3'b010;
      OpLui:    mem_to_reg = 3'b011;
      OpAuipc:  mem_to_reg = 3'b100;
      default:  ;
    endcase
  end

  assign state   = state_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign mem_err = mem_err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with MEM_TIMEOUT=4.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       branch_taken;
  logic       mem_ready;
  logic [2:0] state;
  logic       mem_req, mem_we, ir_write, pc_write, reg_write;
  logic [1:0] pc_mux;
  logic [2:0] mem_to_reg;
  logic       alu_src;
  logic [1:0] alu_op;
  logic [2:0] mem_offset;
  logic       unsigned_flag, halted, illegal, mem_err;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control_unit #(
    .MEM_TIMEOUT   (4),
    .HALT_ON_SYSTEM(1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct3       (funct3),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .state        (state),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .pc_mux       (pc_mux),
    .mem_to_reg   (mem_to_reg),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .mem_offset   (mem_offset),
    .unsigned_flag(unsigned_flag),
    .halted       (halted),
    .illegal      (illegal),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first FETCH cycle.
  task automatic reset_dut();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; opcode = '0; funct3 = '0; branch_taken = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    check_eq("reset_state", state, 0);
    check_eq("reset_outs", {mem_req, mem_we, ir_write, pc_write, reg_write, pc_mux, mem_to_reg,
                            alu_src, alu_op, mem_offset, unsigned_flag, halted, illegal, mem_err}, 0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_to_fetch", state, 1);

    // ADD, zero-wait
    opcode = 7'b0110011; funct3 = 3'b000; mem_ready = 1'b1; #1;
    check_eq("add_fetch_ctl", {mem_req, mem_we, ir_write, mem_offset}, {1'b1, 1'b0, 1'b1, 3'b100});
    tick(); check_eq("add_decode", {state, ir_write, mem_req}, {3'd2, 1'b0, 1'b0});
    tick(); check_eq("add_exec", {state, alu_op, reg_write, alu_src}, {3'd3, 2'b10, 1'b0, 1'b0});
    tick(); check_eq("add_wb", {state, reg_write, pc_write, pc_mux, mem_to_reg, alu_op},
                     {3'd5, 1'b1, 1'b1, 2'b00, 3'b000, 2'b10});
    tick(); check_eq("add_back_fetch", state, 1);

    // LW with three wait cycles; ready arrives in the 4th (last allowed) request cycle
    opcode = 7'b0000011; funct3 = 3'b010;
    tick(); tick();
    check_eq("lw_exec", {state, alu_src, alu_op}, {3'd3, 1'b1, 2'b00});
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      check_eq("lw_mem", {state, mem_req, mem_we, mem_offset, unsigned_flag},
               {3'd4, 1'b1, 1'b0, 3'b100, 1'b0});
      tick();
    end
    check_eq("lw_wb", {state, mem_to_reg, reg_write, mem_err}, {3'd5, 3'b001, 1'b1, 1'b0});
    tick(); check_eq("lw_back_fetch", state, 1);

    // LBU, zero-wait
    funct3 = 3'b100;
    tick(); tick(); tick();
    check_eq("lbu_mem", {state, mem_offset, unsigned_flag}, {3'd4, 3'b001, 1'b1});
    tick(); check_eq("lbu_wb", {state, mem_to_reg}, {3'd5, 3'b001});
    tick();

    // SB
    opcode = 7'b0100011; funct3 = 3'b000;
    tick(); tick();
    check_eq("sb_exec", {state, alu_src}, {3'd3, 1'b1});
    tick();
    check_eq("sb_mem", {state, mem_req, mem_we, mem_offset, pc_write, pc_mux, reg_write, unsigned_flag},
             {3'd4, 1'b1, 1'b1, 3'b001, 1'b1, 2'b00, 1'b0, 1'b0});
    tick(); check_eq("sb_back_fetch", state, 1);

    // BEQ taken then not taken
    opcode = 7'b1100011; funct3 = 3'b000; branch_taken = 1'b1;
    tick(); tick();
    check_eq("beq_taken", {state, pc_mux, pc_write, alu_op, reg_write}, {3'd3, 2'b11, 1'b1, 2'b01, 1'b0});
    tick(); check_eq("beq_taken_fetch", state, 1);
    branch_taken = 1'b0;
    tick(); tick();
    check_eq("beq_not_taken", {state, pc_mux, pc_write}, {3'd3, 2'b11, 1'b0});
    tick(); check_eq("beq_nt_fetch", state, 1);

    // FENCE
    opcode = 7'b0001111;
    tick(); check_eq("fence_decode", {state, pc_write, pc_mux}, {3'd2, 1'b1, 2'b00});
    tick(); check_eq("fence_fetch", state, 1);

    // JAL
    opcode = 7'b1101111;
    tick(); tick(); tick();
    check_eq("jal_wb", {state, pc_mux, mem_to_reg, alu_src}, {3'd5, 2'b01, 3'b010, 1'b0});
    tick();

    // Illegal opcode
    opcode = 7'b0000000;
    tick(); tick();
    check_eq("bad_op_trap", {state, illegal, halted}, {3'd7, 1'b1, 1'b0});
    tick(); tick(); tick();
    check_eq("trap_absorb", {state, mem_req, mem_we, ir_write, pc_write, reg_write, illegal},
             {3'd7, 5'b0, 1'b1});

    reset_dut();
    check_eq("flags_cleared", {halted, illegal, mem_err, state}, {3'b000, 3'd1});
    // Load with reserved funct3
    opcode = 7'b0000011; funct3 = 3'b011; mem_ready = 1'b1;
    tick(); tick();
    check_eq("bad_load_trap", {state, illegal}, {3'd7, 1'b1});

    reset_dut();
    // ECALL halts
    opcode = 7'b1110011; funct3 = 3'b000; mem_ready = 1'b1;
    tick(); tick();
    check_eq("ecall_halt", {state, halted, illegal}, {3'd6, 1'b1, 1'b0});
    tick(); tick();
    check_eq("halt_absorb", {state, mem_req, pc_write, halted}, {3'd6, 1'b0, 1'b0, 1'b1});

    reset_dut();
    // Fetch timeout: four request cycles without ready
    for (int i = 0; i < 4; i++) begin
      check_eq("to_fetch_wait", {state, mem_req, mem_err}, {3'd1, 1'b1, 1'b0});
      tick();
    end
    check_eq("to_trap", {state, mem_err, illegal, mem_req}, {3'd7, 1'b1, 1'b0, 1'b0});

    reset_dut();
    // Ready in the 4th request cycle wins
    opcode = 7'b0110011; funct3 = 3'b000;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    check_eq("to_ready_last", {state, mem_err}, {3'd2, 1'b0});

    reset_dut();
    // Asynchronous reset in the middle of a memory request
    opcode = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    check_eq("mid_mem_req", {state, mem_req}, {3'd4, 1'b1});
    rst_n = 1'b0;
    #1;
    check_eq("async_reset", {state, mem_req, mem_we}, {3'd0, 1'b0, 1'b0});
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_reset_fetch", state, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
